// File: rtl/mod113_mult_seq.sv
// ============================================================================
// Module      : mod113_mult_seq
// Description : Sequential mod-113 multiplier controller. Splits both 7-bit
//               residues into three 3-bit digits, walks the nine digit pairs
//               through an external combinational partial-product LUT bank
//               (one pair per cycle) and accumulates the returned residues
//               modulo MOD. Valid/ready handshake on both sides.
//               Optional macro MOD113_RANGE_CHK_EN: operands >= MOD bypass the
//               digit walk and complete next cycle with out_r=0, out_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mod113_mult_seq #(
    parameter int MOD = 113,
    parameter int W   = 7,
    parameter int DW  = 3,
    parameter int ND  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic [DW-1:0] pp_a,
    output logic [DW-1:0] pp_b,
    output logic [2:0]    pp_w,
    input  logic [W-1:0]  pp_r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_r,
    output logic          out_err
);

    localparam int            c_IW    = (ND > 1) ? $clog2(ND) : 1;
    localparam int            c_PAD   = ND * DW - W;
    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_CALC  = 2'd1;
    localparam logic [1:0]    c_DONE  = 2'd2;
    localparam logic [W:0]    c_MOD_X = (W+1)'(MOD);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(ND - 1);

    logic [1:0]         r_state;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_acc;
    logic [c_IW-1:0]    r_i;
    logic [c_IW-1:0]    r_j;
    logic [W-1:0]       r_out_r;
    logic               r_out_valid;

    logic [ND*DW-1:0]   w_a_pad;
    logic [ND*DW-1:0]   w_b_pad;
    logic [W:0]         w_sum;
    logic [W-1:0]       w_acc_next;
    logic               w_oor;

    // Zero-extend operands so the top digit can be selected like the others
    assign w_a_pad   = {{c_PAD{1'b0}}, r_a};
    assign w_b_pad   = {{c_PAD{1'b0}}, r_b};

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;

`ifdef MOD113_RANGE_CHK_EN
    logic r_out_err;

    assign w_oor   = (in_a >= W'(MOD)) || (in_b >= W'(MOD));
    assign out_err = r_out_err;

    // Error flag: set on an out-of-range accept, cleared when the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_err <= 1'b0;
        end else if ((r_state == c_IDLE) && in_valid && w_oor) begin
            r_out_err <= 1'b1;
        end else if ((r_state == c_DONE) && out_ready) begin
            r_out_err <= 1'b0;
        end
    end
`else
    assign w_oor   = 1'b0;
    assign out_err = 1'b0;
`endif

    // Digit pair and weight to the LUT bank; held at zero outside CALC so the bank is static
    always_comb begin
        pp_a = '0;
        pp_b = '0;
        pp_w = '0;
        if (r_state == c_CALC) begin
            pp_a = w_a_pad[r_i*DW +: DW];
            pp_b = w_b_pad[r_j*DW +: DW];
            pp_w = 3'({1'b0, r_i} + {1'b0, r_j});
        end
    end

    // Modular accumulate: both terms < MOD, so the sum < 2*MOD needs one conditional subtract
    always_comb begin
        w_sum      = {1'b0, r_acc} + {1'b0, pp_r};
        w_acc_next = w_sum[W-1:0];
        if (w_sum >= c_MOD_X) begin
            w_acc_next = W'(w_sum - c_MOD_X);
        end
    end

    // Control FSM: accept operands, walk pairs j-inner/i-outer, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_out_r     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        if (w_oor) begin
                            r_out_r     <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_a     <= in_a;
                            r_b     <= in_b;
                            r_acc   <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_state <= c_CALC;
                        end
                    end
                end
                c_CALC: begin
                    r_acc <= w_acc_next;
                    if (r_j == c_LAST) begin
                        r_j <= '0;
                        if (r_i == c_LAST) begin
                            r_i         <= '0;
                            r_out_r     <= w_acc_next;
                            r_out_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod113_mult_seq.sv
// ============================================================================
// Module      : tb_mod113_mult_seq
// Description : Self-checking bench for mod113_mult_seq. Supplies the LUT bank
//               from an arithmetic model and compares results with (a*b)%113.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mod113_mult_seq;

    localparam int MOD = 113;
    // Result register is written on the 9th edge after the accept edge
    // (the 10th cycle counting the accept cycle).
    localparam int EXP_LAT = 9;

    typedef struct {
        int a;
        int b;
        int exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] in_a = '0;
    logic [6:0] in_b = '0;
    logic [6:0] pp_r;
    logic [6:0] out_r;
    logic [2:0] pp_a, pp_b, pp_w;
    logic       in_ready, out_valid, out_err;

    int n_checks = 0;
    int n_fail   = 0;

    int   res, lat, pe, es;
    vec_t vecs[6];
    int   exp_w[9];
    int   seq_w[9];
    int   ops_a[3], ops_b[3], got[3], tcyc[3];

    always #5 clk = ~clk;

    mod113_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .pp_a      (pp_a),
        .pp_b      (pp_b),
        .pp_w      (pp_w),
        .pp_r      (pp_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_err   (out_err)
    );

    // External partial-product bank: (a_i * b_j * 8^k) mod 113
    always_comb pp_r = 7'((int'(pp_a) * int'(pp_b) * (8 ** int'(pp_w))) % MOD);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE and wait for out_valid; checks the digit walk on the way
    task automatic run_op(input int a, input int b, output int r, output int l,
                          output int ppe, output int errs);
        int ea, eb, ew;
        in_a = 7'(a);
        in_b = 7'(b);
        in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        l = 0; ppe = 0; errs = 0;
        while (!out_valid && l < 40) begin
            if (l < 9) begin
                ea = (a / (8 ** (l / 3))) % 8;
                eb = (b / (8 ** (l % 3))) % 8;
                ew = l / 3 + l % 3;
                if (int'(pp_a) != ea || int'(pp_b) != eb || int'(pp_w) != ew || in_ready)
                    ppe++;
            end
            if (out_err) errs = 1;
            @(posedge clk) #1;
            l++;
        end
        r = int'(out_r);
        if (out_err) errs = 1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        check("hs_out_valid_low", int'(out_valid), 0);
        check("hs_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int a, b;
        int k_acc, k_res;
        logic was_ready;

        vecs[0] = '{112, 112, 1};
        vecs[1] = '{100, 50, 28};
        vecs[2] = '{1, 57, 57};
        vecs[3] = '{0, 99, 0};
        vecs[4] = '{64, 64, 28};
        vecs[5] = '{112, 1, 112};
        exp_w   = '{0, 1, 2, 1, 2, 3, 2, 3, 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_r", int'(out_r), 0);
        check("rst_out_err", int'(out_err), 0);
        check("rst_pp", int'({pp_a, pp_b, pp_w}), 0);
        rst_n = 1'b1;
        @(posedge clk) #1;
        check("post_rst_in_ready", int'(in_ready), 1);

        // Directed vector table
        foreach (vecs[v]) begin
            run_op(vecs[v].a, vecs[v].b, res, lat, pe, es);
            check($sformatf("vec%0d_out_r", v), res, vecs[v].exp);
            check($sformatf("vec%0d_latency", v), lat, EXP_LAT);
            check($sformatf("vec%0d_pp_walk", v), pe, 0);
            handshake();
        end

        // Explicit weight sequence for 112*112
        in_a = 7'd112; in_b = 7'd112; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            seq_w[k] = int'(pp_w);
            @(posedge clk) #1;
        end
        check("seq_out_valid", int'(out_valid), 1);
        check("seq_out_r", int'(out_r), 1);
        for (int k = 0; k < 9; k++) check($sformatf("pp_w[%0d]", k), seq_w[k], exp_w[k]);
        handshake();

        // Random operands against (a*b) mod 113
        for (int n = 0; n < 20; n++) begin
            a = int'($urandom_range(0, MOD - 1));
            b = int'($urandom_range(0, MOD - 1));
            run_op(a, b, res, lat, pe, es);
            check($sformatf("rand_%0dx%0d", a, b), res, (a * b) % MOD);
            check("rand_pp_walk", pe, 0);
            handshake();
        end

        // Backpressure: result held, no new accept
        run_op(100, 50, res, lat, pe, es);
        check("bp_first", res, 28);
        in_a = 7'd3; in_b = 7'd4; in_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk) #1;
            if (!out_valid || int'(out_r) != 28 || in_ready) bad++;
        end
        check("bp_hold", bad, 0);
        in_valid = 1'b0;
        handshake();
        run_op(3, 4, res, lat, pe, es);
        check("bp_next", res, 12);
        handshake();

        // Back-to-back with in_valid and out_ready held high
        ops_a = '{17, 111, 90};
        ops_b = '{33, 2, 105};
        k_acc = 0; k_res = 0;
        in_a = 7'(ops_a[0]); in_b = 7'(ops_b[0]);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && k_res < 3; cyc++) begin
            was_ready = in_ready;
            @(posedge clk) #1;
            if (was_ready && in_valid) begin
                k_acc++;
                if (k_acc < 3) begin
                    in_a = 7'(ops_a[k_acc]);
                    in_b = 7'(ops_b[k_acc]);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                got[k_res]  = int'(out_r);
                tcyc[k_res] = cyc;
                k_res++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", k_res, 3);
        if (k_res == 3) begin
            for (int k = 0; k < 3; k++)
                check($sformatf("b2b_res%0d", k), got[k], (ops_a[k] * ops_b[k]) % MOD);
            check("b2b_spacing01", tcyc[1] - tcyc[0], 11);
            check("b2b_spacing12", tcyc[2] - tcyc[1], 11);
        end
        @(posedge clk) #1;

        // Reset in the middle of CALC
        in_a = 7'd77; in_b = 7'd88; in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midcalc_busy", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("midcalc_rst_in_ready", int'(in_ready), 1);
        check("midcalc_rst_out", int'({out_valid, out_r, out_err}), 0);
        check("midcalc_rst_pp", int'({pp_a, pp_b, pp_w}), 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (15) begin
            @(posedge clk) #1;
            if (out_valid) bad++;
        end
        check("midcalc_no_spurious", bad, 0);
        run_op(77, 88, res, lat, pe, es);
        check("midcalc_next_op", res, (77 * 88) % MOD);
        handshake();

        // Reset while a result is pending
        run_op(5, 6, res, lat, pe, es);
        check("middone_res", res, 30);
        rst_n = 1'b0;
        #1;
        check("middone_rst_out", int'({out_valid, out_r}), 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        check("middone_in_ready", int'(in_ready), 1);

        // Out-of-range operand
        run_op(113, 5, res, lat, pe, es);
`ifdef MOD113_RANGE_CHK_EN
        check("oor_err", es, 1);
        check("oor_out_r", res, 0);
        check("oor_latency", lat, 0);
`else
        check("oor_err_off", es, 0);
        check("oor_latency_off", lat, EXP_LAT);
`endif
        handshake();
        check("oor_err_cleared", int'(out_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
